// File: rtl/audio_mix_pkg.sv
// -----------------------------------------------------------------------------
// audio_mix_pkg
// Shared types and constants for the audio output mix scheduler.
//   mix_state_t  : scheduler FSM states
//   HOLD_CYCLES  : cycles spent in HOLD waiting for audio_out_allowed to settle
//   GUARD_BITS   : accumulator headroom above the sample width (8 sources)
//   UNDERRUN_W   : width of each per-source underrun counter (optional feature)
// -----------------------------------------------------------------------------
package audio_mix_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GATHER,
    SCALE,
    WRITE,
    HOLD
  } mix_state_t;

  localparam int HOLD_CYCLES = 2;
  localparam int GUARD_BITS  = 3;
  localparam int UNDERRUN_W  = 16;

endpackage

// File: rtl/audio_mix_sat.sv
// -----------------------------------------------------------------------------
// audio_mix_sat
// Combinational master attenuation and saturation of one mix accumulator.
// Ports:
//   acc_in  in  DATA_W+GUARD_BITS  signed accumulator
//   shift   in  3                  arithmetic right shift amount 0..7
//   sat_out out DATA_W             shifted value clamped to the DATA_W range
// -----------------------------------------------------------------------------
module audio_mix_sat
  import audio_mix_pkg::*;
#(
  parameter int DATA_W = 29
) (
  input  logic signed [DATA_W+GUARD_BITS-1:0] acc_in,
  input  logic        [2:0]                   shift,
  output logic signed [DATA_W-1:0]            sat_out
);

  localparam int ACC_W = DATA_W + GUARD_BITS;

  // Largest / smallest DATA_W values, expressed at accumulator width so the
  // comparisons below stay signed and full width.
  localparam logic signed [ACC_W-1:0] MAX_V = {{(GUARD_BITS+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(GUARD_BITS+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here via the if/else chain) so no latch is inferred.
  always_comb begin
    shifted = acc_in >>> shift;
    if (shifted > MAX_V) begin
      sat_out = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      sat_out = MIN_V[DATA_W-1:0];
    end else begin
      sat_out = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/audio_out_mix_scheduler.sv
// -----------------------------------------------------------------------------
// audio_out_mix_scheduler
// Shares the codec playback path among N_SRC sample producers. Each time the
// audio controller reports FIFO space, every source is visited once in
// round-robin order, the stereo samples are summed, attenuated by mix_shift,
// saturated and written to the controller with a single write_audio_out.
//
// Ports:
//   CLOCK_50, reset            clock, synchronous active-high reset
//   mix_enable                 0 = no new mix cycles start
//   flush                      abort current mix, clear codec FIFO next cycle
//   mix_shift[2:0]             master attenuation (arithmetic right shift)
//   src_en/src_valid[N_SRC]    per-source enable / sample ready
//   src_left/src_right         packed samples, source i at [i*DATA_W +: DATA_W]
//   src_ready[N_SRC]           1-cycle consume pulse
//   audio_out_allowed          FIFO space flag from the controller
//   left/right_channel_audio_out  mixed samples, stable between SCALE states
//   write_audio_out            1-cycle write strobe
//   clear_audio_out_memory     FIFO clear strobe
//   busy                       FSM not idle
// Optional (macro AUDIO_MIX_UNDERRUN_CNT_EN):
//   underrun_clr               clears all underrun counters
//   underrun_cnt[N_SRC*16]     per-source saturating underrun counters
// -----------------------------------------------------------------------------
module audio_out_mix_scheduler
  import audio_mix_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 29
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      mix_enable,
  input  logic                      flush,
  input  logic [2:0]                mix_shift,
  input  logic [N_SRC-1:0]          src_en,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*DATA_W-1:0]   src_left,
  input  logic [N_SRC*DATA_W-1:0]   src_right,
  output logic [N_SRC-1:0]          src_ready,
  input  logic                      audio_out_allowed,
  output logic [DATA_W-1:0]         left_channel_audio_out,
  output logic [DATA_W-1:0]         right_channel_audio_out,
  output logic                      write_audio_out,
  output logic                      clear_audio_out_memory,
`ifdef AUDIO_MIX_UNDERRUN_CNT_EN
  input  logic                      underrun_clr,
  output logic [N_SRC*UNDERRUN_W-1:0] underrun_cnt,
`endif
  output logic                      busy
);

  localparam int ACC_W  = DATA_W + GUARD_BITS;
  localparam int IDX_W  = $clog2(N_SRC);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_SRC - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);

  mix_state_t               state, state_nxt;
  logic [IDX_W-1:0]         idx;
  logic [HOLD_W-1:0]        hold_cnt;
  logic signed [ACC_W-1:0]  acc_l, acc_r;
  logic signed [DATA_W-1:0] sel_l, sel_r;
  logic signed [DATA_W-1:0] sat_l, sat_r;
  logic                     start_mix;

  assign sel_l     = src_left [idx*DATA_W +: DATA_W];
  assign sel_r     = src_right[idx*DATA_W +: DATA_W];
  assign start_mix = mix_enable & audio_out_allowed;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and combinational strobes. flush overrides everything: no ready,
  // no write, straight back to IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt       = state;
    src_ready       = '0;
    write_audio_out = 1'b0;

    case (state)
      IDLE:    if (start_mix) state_nxt = GATHER;
      GATHER: begin
        src_ready[idx] = src_en[idx] & src_valid[idx];
        if (idx == LAST_IDX) state_nxt = SCALE;
      end
      SCALE:   state_nxt = WRITE;
      WRITE: begin
        write_audio_out = 1'b1;
        state_nxt       = HOLD;
      end
      // audio_out_allowed lags the FIFO write, so it is not looked at here.
      HOLD:    if (hold_cnt == LAST_HOLD) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (flush) begin
      state_nxt       = IDLE;
      src_ready       = '0;
      write_audio_out = 1'b0;
    end
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Datapath: source index, accumulators, hold counter, output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      idx                     <= '0;
      hold_cnt                <= '0;
      acc_l                   <= '0;
      acc_r                   <= '0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
      clear_audio_out_memory  <= 1'b0;
    end else begin
      clear_audio_out_memory <= flush;
      if (flush) begin
        // Channel outputs intentionally keep their last value.
        idx      <= '0;
        hold_cnt <= '0;
        acc_l    <= '0;
        acc_r    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_mix) begin
              idx   <= '0;
              acc_l <= '0;
              acc_r <= '0;
            end
          end
          GATHER: begin
            // Underrun or disabled sources simply add nothing; no stall.
            if (src_ready[idx]) begin
              acc_l <= acc_l + {{GUARD_BITS{sel_l[DATA_W-1]}}, sel_l};
              acc_r <= acc_r + {{GUARD_BITS{sel_r[DATA_W-1]}}, sel_r};
            end
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          end
          SCALE: begin
            left_channel_audio_out  <= sat_l;
            right_channel_audio_out <= sat_r;
            hold_cnt                <= '0;
          end
          HOLD:    hold_cnt <= hold_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

  audio_mix_sat #(.DATA_W(DATA_W)) u_sat_l (
    .acc_in  (acc_l),
    .shift   (mix_shift),
    .sat_out (sat_l)
  );

  audio_mix_sat #(.DATA_W(DATA_W)) u_sat_r (
    .acc_in  (acc_r),
    .shift   (mix_shift),
    .sat_out (sat_r)
  );

`ifdef AUDIO_MIX_UNDERRUN_CNT_EN
  // ---------------------------------------------------------------------------
  // Per-source underrun counters: count visits where the source was enabled
  // but had no sample. Saturate at all-ones; clear wins over increment.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_urun
    logic [UNDERRUN_W-1:0] cnt_q;

    always_ff @(posedge CLOCK_50) begin
      if (reset || underrun_clr) begin
        cnt_q <= '0;
      end else if (state == GATHER && idx == IDX_W'(gi) &&
                   src_en[gi] && !src_valid[gi] && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign underrun_cnt[gi*UNDERRUN_W +: UNDERRUN_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_audio_out_mix_scheduler.sv
// -----------------------------------------------------------------------------
// tb_audio_out_mix_scheduler
// Scoreboard bench: directed stimulus pushes the hand-computed mix result into
// a queue; a monitor pops and compares on every write_audio_out and logs
// src_ready / clear strobes with their cycle numbers for timing checks.
// -----------------------------------------------------------------------------
module tb_audio_out_mix_scheduler;
  import audio_mix_pkg::*;

  localparam int N_SRC  = 4;
  localparam int DATA_W = 29;

  logic                    CLOCK_50 = 1'b0;
  logic                    reset = 1'b1;
  logic                    mix_enable = 1'b0;
  logic                    flush = 1'b0;
  logic [2:0]              mix_shift = 3'd0;
  logic [N_SRC-1:0]        src_en = '1;
  logic [N_SRC-1:0]        src_valid = '1;
  logic [N_SRC*DATA_W-1:0] src_left = '0;
  logic [N_SRC*DATA_W-1:0] src_right = '0;
  logic [N_SRC-1:0]        src_ready;
  logic                    audio_out_allowed = 1'b1;
  logic [DATA_W-1:0]       left_channel_audio_out;
  logic [DATA_W-1:0]       right_channel_audio_out;
  logic                    write_audio_out;
  logic                    clear_audio_out_memory;
  logic                    busy;
`ifdef AUDIO_MIX_UNDERRUN_CNT_EN
  logic                    underrun_clr = 1'b0;
  logic [N_SRC*UNDERRUN_W-1:0] underrun_cnt;
`endif

  audio_out_mix_scheduler #(.N_SRC(N_SRC), .DATA_W(DATA_W)) dut (
    .CLOCK_50                (CLOCK_50),
    .reset                   (reset),
    .mix_enable              (mix_enable),
    .flush                   (flush),
    .mix_shift               (mix_shift),
    .src_en                  (src_en),
    .src_valid               (src_valid),
    .src_left                (src_left),
    .src_right               (src_right),
    .src_ready               (src_ready),
    .audio_out_allowed       (audio_out_allowed),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .write_audio_out         (write_audio_out),
    .clear_audio_out_memory  (clear_audio_out_memory),
`ifdef AUDIO_MIX_UNDERRUN_CNT_EN
    .underrun_clr            (underrun_clr),
    .underrun_cnt            (underrun_cnt),
`endif
    .busy                    (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct { longint l; longint r; } exp_t;
  typedef struct { int c; logic [N_SRC-1:0] r; } rdy_t;

  exp_t exp_q[$];
  rdy_t rdy_q[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;
  int n_writes = 0;
  int last_write_cyc = -1;
  int n_clears = 0;
  int last_clear_cyc = -1;
  int last_t = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge CLOCK_50) begin
    if (src_ready != '0) rdy_q.push_back('{cyc, src_ready});
    if (clear_audio_out_memory) begin
      n_clears++;
      last_clear_cyc = cyc;
    end
    if (write_audio_out) begin
      n_writes++;
      last_write_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("mix_left",  longint'($signed(left_channel_audio_out)),  mon_e.l);
        check("mix_right", longint'($signed(right_channel_audio_out)), mon_e.r);
      end
    end
  end

  task automatic set_src(input int i, input int l, input int r);
    src_left [i*DATA_W +: DATA_W] = DATA_W'(l);
    src_right[i*DATA_W +: DATA_W] = DATA_W'(r);
  endtask

  // Raise mix_enable in cycle t (returned) until the DUT leaves IDLE.
  task automatic start_mix(output int t);
    @(posedge CLOCK_50); #1;
    mix_enable = 1'b1;
    t = cyc;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLOCK_50); #1;
      if (busy) break;
    end
    check("mix_started", longint'(busy), 1);
    mix_enable = 1'b0;
  endtask

  task automatic wait_write(input int n_before, input int t_exp, input string name);
    for (int k = 0; k < 40; k++) begin
      if (n_writes != n_before) break;
      @(posedge CLOCK_50);
    end
    #1;
    check(name, longint'(last_write_cyc), longint'(t_exp));
  endtask

  task automatic wait_idle();
    repeat (5) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic run_mix(input longint el, input longint er, input string name);
    int t;
    int nw;
    exp_q.push_back('{el, er});
    rdy_q.delete();
    nw = n_writes;
    start_mix(t);
    last_t = t;
    wait_write(nw, t + N_SRC + 2, name);
    wait_idle();
  endtask

  initial begin
    int t;
    int nw;
    int nc;
    logic [N_SRC-1:0] rdy_or;
`ifdef AUDIO_MIX_UNDERRUN_CNT_EN
    int c0;
`endif

    // ---------------- reset state ----------------
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_left",  longint'(left_channel_audio_out), 0);
    check("rst_right", longint'(right_channel_audio_out), 0);
    check("rst_write", longint'(write_audio_out), 0);
    check("rst_clear", longint'(clear_audio_out_memory), 0);
    check("rst_busy",  longint'(busy), 0);
    check("rst_ready", longint'(src_ready), 0);
    reset = 1'b0;

    // ---------------- basic mix ----------------
    set_src(0, 100, 1);
    set_src(1, 200, -2);
    set_src(2, -50, 3);
    set_src(3, 0, -4);
    mix_shift = 3'd0;
    run_mix(250, -2, "basic_latency");
    check("basic_ready_count", longint'(rdy_q.size()), N_SRC);
    for (int i = 0; i < rdy_q.size() && i < N_SRC; i++) begin
      check("basic_ready_cyc", longint'(rdy_q[i].c), longint'(last_t + 1 + i));
      check("basic_ready_bit", longint'(rdy_q[i].r), longint'(1 << i));
    end

    // ---------------- saturation ----------------
    for (int i = 0; i < N_SRC; i++) set_src(i, 134217728, i + 1);
    run_mix(268435455, 10, "sat_pos_latency");
    for (int i = 0; i < N_SRC; i++) set_src(i, -134217728, -1);
    run_mix(-268435456, -4, "sat_neg_latency");
    mix_shift = 3'd2;
    for (int i = 0; i < N_SRC; i++) set_src(i, 134217728, -1);
    run_mix(134217728, -1, "shift2_latency");
    mix_shift = 3'd0;

    // ---------------- underrun and disable ----------------
    for (int i = 0; i < N_SRC; i++) set_src(i, 10, 10);
    src_valid = 4'b1011;
    src_en    = 4'b0111;
`ifdef AUDIO_MIX_UNDERRUN_CNT_EN
    c0 = int'(underrun_cnt[2*UNDERRUN_W +: UNDERRUN_W]);
`endif
    run_mix(20, 20, "underrun_latency");
    rdy_or = '0;
    foreach (rdy_q[i]) rdy_or |= rdy_q[i].r;
    check("underrun_ready_count", longint'(rdy_q.size()), 2);
    check("underrun_ready_bits", longint'(rdy_or), 3);
`ifdef AUDIO_MIX_UNDERRUN_CNT_EN
    check("underrun_cnt_1", longint'(underrun_cnt[2*UNDERRUN_W +: UNDERRUN_W]), longint'(c0 + 1));
    run_mix(20, 20, "underrun2_latency");
    check("underrun_cnt_2", longint'(underrun_cnt[2*UNDERRUN_W +: UNDERRUN_W]), longint'(c0 + 2));
    check("underrun_cnt_3", longint'(underrun_cnt[3*UNDERRUN_W +: UNDERRUN_W]), 0);
`endif
    src_valid = '1;
    src_en    = '1;

    // ---------------- backpressure ----------------
    @(posedge CLOCK_50); #1;
    audio_out_allowed = 1'b0;
    mix_enable = 1'b1;
    rdy_q.delete();
    nw = n_writes;
    repeat (10) @(posedge CLOCK_50);
    #1;
    check("bp_no_ready", longint'(rdy_q.size()), 0);
    check("bp_no_write", longint'(n_writes), longint'(nw));
    check("bp_idle", longint'(busy), 0);
    exp_q.push_back('{40, 40});
    exp_q.push_back('{40, 40});
    audio_out_allowed = 1'b1;
    t = cyc;
    wait_write(nw, t + N_SRC + 2, "bp_latency");
    wait_write(nw + 1, t + 2 * N_SRC + 7, "bp_period");
    mix_enable = 1'b0;
    wait_idle();
    check("bp_write_count", longint'(n_writes), longint'(nw + 2));

    // ---------------- flush mid-GATHER at idx=1 ----------------
    set_src(0, 100, 1);
    set_src(1, 200, -2);
    set_src(2, -50, 3);
    set_src(3, 0, -4);
    rdy_q.delete();
    nw = n_writes;
    nc = n_clears;
    start_mix(t);                 // now in cycle t+1 (idx 0)
    @(posedge CLOCK_50); #1;      // cycle t+2 (idx 1)
    flush = 1'b1;
    @(posedge CLOCK_50); #1;
    flush = 1'b0;
    repeat (12) @(posedge CLOCK_50);
    #1;
    check("flush_clear_count", longint'(n_clears), longint'(nc + 1));
    check("flush_clear_cyc", longint'(last_clear_cyc), longint'(t + 3));
    check("flush_no_write", longint'(n_writes), longint'(nw));
    check("flush_idle", longint'(busy), 0);
    check("flush_ready_count", longint'(rdy_q.size()), 1);
    run_mix(250, -2, "post_flush_latency");

    // ---------------- reset mid-WRITE ----------------
    exp_q.push_back('{250, -2});
    nw = n_writes;
    start_mix(t);                 // cycle t+1
    repeat (5) @(posedge CLOCK_50);
    #1;                           // cycle t+6 = WRITE
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    check("rstw_left",  longint'(left_channel_audio_out), 0);
    check("rstw_right", longint'(right_channel_audio_out), 0);
    check("rstw_busy",  longint'(busy), 0);
    check("rstw_write", longint'(write_audio_out), 0);
    repeat (15) @(posedge CLOCK_50);
    #1;
    check("rstw_write_count", longint'(n_writes), longint'(nw + 1));

    check("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/audio_out_mix_scheduler.md
Name: audio_out_mix_scheduler

Overview:
- Shares the codec playback path among N_SRC sample producers (instrument voices, drum engine, metronome).
- Each time the audio controller reports FIFO space, the block visits every source once in round-robin order and collects one stereo sample from each.
- It sums and attenuates the samples, saturates the result, and issues exactly one write_audio_out pulse.
- Sits between the voice generators and the audio controller's left/right_channel_audio_out, write_audio_out, audio_out_allowed and clear_audio_out_memory ports.

Parameters:
- N_SRC, 4, number of sample sources (2..8).
- DATA_W, 29, signed sample width; matches the controller's channel width.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- mix_enable  in  1  0 = no new mix cycles are started.
- flush  in  1  1-cycle pulse: abort the current mix and clear the codec output FIFO.
- mix_shift  in  3  master attenuation, arithmetic right shift 0..7 applied to the sum.
- src_en  in  N_SRC  per-source enable.
- src_valid  in  N_SRC  source i has a stereo sample ready.
- src_left  in  N_SRC*DATA_W  packed; source i occupies [i*DATA_W +: DATA_W].
- src_right  in  N_SRC*DATA_W  packed, same layout as src_left.
- src_ready  out  N_SRC  1-cycle pulse; sample consumed.
- audio_out_allowed  in  1  from the audio controller.
- left_channel_audio_out  out  DATA_W  mixed sample.
- right_channel_audio_out  out  DATA_W  mixed sample.
- write_audio_out  out  1  1-cycle write strobe.
- clear_audio_out_memory  out  1  FIFO clear strobe.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; accumulators 0; source index 0.
- Accumulators: signed, DATA_W+3 bits, which holds 8 full-scale sources without overflow.
- IDLE
  - If mix_enable & audio_out_allowed: clear both accumulators, set idx=0, go to GATHER.
- GATHER, exactly N_SRC cycles, idx = 0..N_SRC-1
  - src_ready[idx] = src_en[idx] & src_valid[idx], combinational, and only in that cycle.
  - When src_ready[idx] is 1, add the sign-extended left and right samples to the accumulators.
  - A source that is enabled but not valid contributes 0 (underrun). There is no stall; playback is real-time.
  - A disabled source contributes 0 and receives no ready pulse.
  - After idx = N_SRC-1, go to SCALE.
- SCALE, 1 cycle
  - Arithmetic right shift of each accumulator by mix_shift.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register the results into left/right_channel_audio_out.
- WRITE, 1 cycle
  - write_audio_out = 1.
  - Output data are held stable from SCALE until the next SCALE.
- HOLD, 2 cycles
  - audio_out_allowed is a registered flag and lags the FIFO write, so it is ignored here.
  - Then go to IDLE.
- Latency: IDLE decision cycle t, write_audio_out at t+N_SRC+2. Minimum write period is N_SRC+5 cycles.
- flush
  - Takes priority in any state: clear_audio_out_memory = 1 in the following cycle.
  - FSM goes to IDLE and accumulators clear.
  - No src_ready or write_audio_out is issued in that cycle.
  - Channel outputs keep their last value.
- mix_enable deasserted mid-cycle: the current mix completes through HOLD, then the FSM stays in IDLE.
- src_en changed mid-GATHER: the value sampled at each source's own idx cycle applies.
- busy = 1 in every state except IDLE.

Optional Feature:
- Macro: AUDIO_MIX_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_cnt, N_SRC*16 bits, packed per source.
  - Source i's counter increments, saturating at 0xFFFF, when idx=i in GATHER with src_en[i] & ~src_valid[i].
  - Adds input underrun_clr, which zeros all counters and has priority over increment.
  - Counters reset to 0.
- When undefined: neither port exists and there is no counter logic.

Decomposition:
- Package audio_mix_pkg holds:
  - the FSM state enum (IDLE, GATHER, SCALE, WRITE, HOLD);
  - HOLD_CYCLES = 2;
  - GUARD_BITS = 3;
  - UNDERRUN_W = 16.
- One sub-module, audio_mix_sat: combinational shift plus saturation of one DATA_W+3 accumulator to DATA_W. Instantiated twice, left and right.

Test Plan:
- Basic mix: N_SRC=4, all enabled and valid.
  - Left inputs 100, 200, -50, 0; mix_shift=0.
  - Expect write_audio_out with left=250.
  - Expect src_ready pulses in cycles t+1..t+4, one per source in order.
- Saturation: all four left = 2^27, mix_shift=0.
  - Expect left = 2^28-1; the negative mirror case gives -2^28.
  - mix_shift=2 gives 2^27.
- Underrun and disable:
  - src_valid[2]=0, src_en[3]=0, inputs 10 each: expect sum 20.
  - src_ready[2] and src_ready[3] never assert.
  - With the macro defined, underrun_cnt[2] increments by 1 per mix cycle.
- Backpressure: audio_out_allowed held 0.
  - No src_ready and no write while it is 0.
  - Raise it at cycle t: write at t+6 for N_SRC=4.
  - The next write is not earlier than 9 cycles later.
- Flush mid-GATHER at idx=1:
  - clear_audio_out_memory pulses once.
  - No write_audio_out follows; FSM returns to IDLE.
  - The next mix starts from zeroed accumulators.
- Reset mid-WRITE: all outputs 0 in the next cycle, busy=0, no further write strobe.
